smart_cargo_entrada_pedidos: RTL and testbench

SMART_CARGO_ENTRADA_PEDIDOS -- requirements
Module: smart_cargo_entrada_pedidos

---
 rtl/smart_cargo_entrada_pedidos.sv | 230 +++++++++++++++++++++++
 tb/tb_smart_cargo_entrada_pedidos.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smart_cargo_entrada_pedidos.sv
// smart_cargo_entrada_pedidos
//
// Request entry for the cargo elevator. It captures an origin floor (with
// object type) from one-hot origin buttons, waits for a destination floor
// from one-hot destination buttons, and queues complete requests in a
// 4-entry FIFO that the datapath/control unit pops with pedido_aceito.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-high reset
//   origemBot[3:0]   one-hot origin buttons (levels)
//   destinoBot[3:0]  one-hot destination buttons (levels)
//   tipoObjeto[1:0]  object type, sampled with the origin
//   pedido_aceito    pop strobe for the head entry
//   pedido_valido    FIFO not empty
//   pedido_origem    head entry origin (0 when empty)
//   pedido_destino   head entry destination (0 when empty)
//   pedido_tipo      head entry object type (0 when empty)
//   esperandoDestino FSM is waiting for a destination
//   erroPedido       one-cycle pulse when a request is discarded
//   ocupacao[2:0]    FIFO entry count, 0..4
//
// Optional feature: define SMART_CARGO_TIMEOUT_EN to enable the destination
// timeout (TIMEOUT_CICLOS cycles, counter width TIMEOUT_W).

module smart_cargo_entrada_pedidos #(
   parameter int unsigned TIMEOUT_CICLOS = 2000,
   parameter int unsigned TIMEOUT_W      = 14
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] origemBot,
   input  logic [3:0] destinoBot,
   input  logic [1:0] tipoObjeto,
   input  logic       pedido_aceito,
   output logic       pedido_valido,
   output logic [1:0] pedido_origem,
   output logic [1:0] pedido_destino,
   output logic [1:0] pedido_tipo,
   output logic       esperandoDestino,
   output logic       erroPedido,
   output logic [2:0] ocupacao
);

   if (TIMEOUT_CICLOS >= (64'd1 << TIMEOUT_W)) begin : gTimeoutInvalido
      $error("TIMEOUT_CICLOS must be less than 2**TIMEOUT_W");
   end

   typedef enum logic {
      ESPERA_ORIGEM,
      ESPERA_DESTINO
   } estado_t;

   estado_t     estado;
   estado_t     estadoProx;

   logic [1:0]  origemCod;
   logic        origemOk;
   logic [1:0]  destinoCod;
   logic        destinoOk;
   logic        origemAnt;
   logic        destinoAnt;
   logic        posReset;
   logic        origemEvento;
   logic        destinoEvento;
   logic        timeoutAtingido;

   logic [1:0]  origemCap;
   logic [1:0]  tipoCap;
   logic        capturar;
   logic        push;
   logic        pop;
   logic        cheia;

   logic [5:0]  fila [4];
   logic [1:0]  wrPtr;
   logic [1:0]  rdPtr;
   logic [2:0]  contagem;
   logic [5:0]  cabeca;

   // One-hot button decoding; anything else is not a valid press.
   always_comb begin
      origemCod = '0;
      origemOk  = 1'b1;
      case (origemBot)
         4'b0001: origemCod = 2'd0;
         4'b0010: origemCod = 2'd1;
         4'b0100: origemCod = 2'd2;
         4'b1000: origemCod = 2'd3;
         default: origemOk  = 1'b0;
      endcase
   end

   always_comb begin
      destinoCod = '0;
      destinoOk  = 1'b1;
      case (destinoBot)
         4'b0001: destinoCod = 2'd0;
         4'b0010: destinoCod = 2'd1;
         4'b0100: destinoCod = 2'd2;
         4'b1000: destinoCod = 2'd3;
         default: destinoOk  = 1'b0;
      endcase
   end

   // Edge registers hold the previous OR of each bus. posReset masks the first
   // cycle after reset release: the edge registers come out of reset at 0, so a
   // button held through reset would otherwise look like a fresh press.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         origemAnt  <= 1'b0;
         destinoAnt <= 1'b0;
         posReset   <= 1'b1;
      end else begin
         origemAnt  <= |origemBot;
         destinoAnt <= |destinoBot;
         posReset   <= 1'b0;
      end
   end

   assign origemEvento  = (|origemBot)  & ~origemAnt  & ~posReset & origemOk;
   assign destinoEvento = (|destinoBot) & ~destinoAnt & ~posReset & destinoOk;

`ifdef SMART_CARGO_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] timer;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer <= '0;
      end else if (capturar) begin
         timer <= '0;
      end else if (estado == ESPERA_DESTINO) begin
         timer <= timer + 1'b1;
      end
   end

   assign timeoutAtingido = (estado == ESPERA_DESTINO) &&
                            (timer == TIMEOUT_W'(TIMEOUT_CICLOS - 1));
`else
   assign timeoutAtingido = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= ESPERA_ORIGEM;
      end else begin
         estado <= estadoProx;
      end
   end

   // FSM next state: an origin event always wins over a destination event
   always_comb begin
      estadoProx = estado;
      case (estado)
         ESPERA_ORIGEM: begin
            if (origemEvento) estadoProx = ESPERA_DESTINO;
         end
         ESPERA_DESTINO: begin
            if (origemEvento)         estadoProx = ESPERA_DESTINO;
            else if (destinoEvento)   estadoProx = ESPERA_ORIGEM;
            else if (timeoutAtingido) estadoProx = ESPERA_ORIGEM;
         end
         default: estadoProx = ESPERA_ORIGEM;
      endcase
   end

   // FSM outputs; the full check uses the pre-pop count
   assign cheia = (contagem == 3'd4);

   always_comb begin
      esperandoDestino = 1'b0;
      erroPedido       = 1'b0;
      push             = 1'b0;
      capturar         = origemEvento;
      if (estado == ESPERA_DESTINO) begin
         esperandoDestino = 1'b1;
         if (!origemEvento) begin
            if (destinoEvento) begin
               if ((destinoCod == origemCap) || cheia) erroPedido = 1'b1;
               else                                    push       = 1'b1;
            end else if (timeoutAtingido) begin
               erroPedido = 1'b1;
            end
         end
      end
   end

   // Captured origin and object type
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         origemCap <= '0;
         tipoCap   <= '0;
      end else if (capturar) begin
         origemCap <= origemCod;
         tipoCap   <= tipoObjeto;
      end
   end

   // Request FIFO: 4 x {origem, destino, tipo}
   assign pop = pedido_aceito & (contagem != 3'd0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 4; i++) fila[i] <= '0;
         wrPtr    <= '0;
         rdPtr    <= '0;
         contagem <= '0;
      end else begin
         if (push) begin
            fila[wrPtr] <= {origemCap, destinoCod, tipoCap};
            wrPtr       <= wrPtr + 2'd1;
         end
         if (pop) rdPtr <= rdPtr + 2'd1;
         case ({push, pop})
            2'b10:   contagem <= contagem + 3'd1;
            2'b01:   contagem <= contagem - 3'd1;
            default: contagem <= contagem;
         endcase
      end
   end

   assign cabeca         = fila[rdPtr];
   assign pedido_valido  = (contagem != 3'd0);
   assign pedido_origem  = pedido_valido ? cabeca[5:4] : '0;
   assign pedido_destino = pedido_valido ? cabeca[3:2] : '0;
   assign pedido_tipo    = pedido_valido ? cabeca[1:0] : '0;
   assign ocupacao       = contagem;

endmodule

// File: tb/tb_smart_cargo_entrada_pedidos.sv
// tb_smart_cargo_entrada_pedidos
//
// Directed bench with a scoreboard: stimulus pushes expected FIFO entries,
// a monitor compares the head entry whenever it is popped. Flag-type outputs
// are checked directly against hand-computed values.

module tb_smart_cargo_entrada_pedidos;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] origemBot;
   logic [3:0] destinoBot;
   logic [1:0] tipoObjeto;
   logic       pedido_aceito;
   logic       pedido_valido;
   logic [1:0] pedido_origem;
   logic [1:0] pedido_destino;
   logic [1:0] pedido_tipo;
   logic       esperandoDestino;
   logic       erroPedido;
   logic [2:0] ocupacao;

   int total = 0;
   int bad   = 0;
   logic [5:0] sb [$];

   smart_cargo_entrada_pedidos #(
      .TIMEOUT_CICLOS(8),
      .TIMEOUT_W(14)
   ) dut (
      .clock(clock),
      .reset(reset),
      .origemBot(origemBot),
      .destinoBot(destinoBot),
      .tipoObjeto(tipoObjeto),
      .pedido_aceito(pedido_aceito),
      .pedido_valido(pedido_valido),
      .pedido_origem(pedido_origem),
      .pedido_destino(pedido_destino),
      .pedido_tipo(pedido_tipo),
      .esperandoDestino(esperandoDestino),
      .erroPedido(erroPedido),
      .ocupacao(ocupacao)
   );

   always #5 clock = ~clock;

   task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nome, act, exp);
      end
   endtask

   // Scoreboard monitor: compare head entry at each accepted pop
   always @(negedge clock) begin
      if (!reset && pedido_aceito && pedido_valido) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL head: got %0h expected none (scoreboard empty)",
                     {pedido_origem, pedido_destino, pedido_tipo});
         end else begin
            check("head", {pedido_origem, pedido_destino, pedido_tipo}, sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Press origin for one cycle, then release for one cycle
   task automatic origem(input logic [3:0] b, input logic [1:0] t);
      origemBot  = b;
      tipoObjeto = t;
      tick();
      origemBot = '0;
      tick();
   endtask

   // Press destination for one cycle, checking the error pulse in that cycle
   task automatic destino(input logic [3:0] b, input logic expErr);
      destinoBot = b;
      @(negedge clock);
      check("erroPedido", erroPedido, expErr);
      tick();
      destinoBot = '0;
   endtask

   task automatic pop();
      pedido_aceito = 1'b1;
      @(negedge clock);
      tick();
      pedido_aceito = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      origemBot = '0;
      destinoBot = '0;
      tipoObjeto = '0;
      pedido_aceito = 1'b0;
      repeat (2) tick();
      check("rst_valido", pedido_valido, 0);
      check("rst_ocupacao", ocupacao, 0);
      check("rst_esperando", esperandoDestino, 0);
      check("rst_erro", erroPedido, 0);
      check("rst_head", {pedido_origem, pedido_destino, pedido_tipo}, 0);
      reset = 1'b0;
      repeat (2) tick();

      // Basic request: origin 2, type 1, destination 0
      origem(4'b0100, 2'b01);
      check("esperando_apos_origem", esperandoDestino, 1);
      sb.push_back({2'd2, 2'd0, 2'd1});
      destino(4'b0001, 1'b0);
      check("valido_apos_push", pedido_valido, 1);
      check("origem_cabeca", pedido_origem, 2);
      check("destino_cabeca", pedido_destino, 0);
      check("tipo_cabeca", pedido_tipo, 1);
      check("ocupacao_1", ocupacao, 1);
      pop();
      check("ocupacao_pop", ocupacao, 0);
      check("valido_pop", pedido_valido, 0);

      // Destination equal to origin is discarded
      origem(4'b0010, 2'b00);
      destino(4'b0010, 1'b1);
      check("ocupacao_igual", ocupacao, 0);
      check("esperando_igual", esperandoDestino, 0);

      // Invalid origin vector and destination while waiting for an origin
      origem(4'b0011, 2'b00);
      check("origem_invalida", esperandoDestino, 0);
      destino(4'b0001, 1'b0);
      check("destino_sem_origem", ocupacao, 0);

      // A second origin overwrites the first
      origem(4'b0001, 2'b10);
      origem(4'b1000, 2'b11);
      sb.push_back({2'd3, 2'd0, 2'd3});
      destino(4'b0001, 1'b0);
      check("ocupacao_sobrescrita", ocupacao, 1);
      check("origem_sobrescrita", pedido_origem, 3);

      // Fill the FIFO, fifth request rejected
      origem(4'b0010, 2'b00); sb.push_back({2'd1, 2'd2, 2'd0}); destino(4'b0100, 1'b0);
      origem(4'b0100, 2'b10); sb.push_back({2'd2, 2'd3, 2'd2}); destino(4'b1000, 1'b0);
      origem(4'b1000, 2'b01); sb.push_back({2'd3, 2'd1, 2'd1}); destino(4'b0010, 1'b0);
      check("ocupacao_cheia", ocupacao, 4);
      origem(4'b0001, 2'b00);
      destino(4'b0010, 1'b1);
      check("ocupacao_quinto", ocupacao, 4);
      check("esperando_quinto", esperandoDestino, 0);

      // Push with full FIFO and simultaneous pop: push rejected, count drops
      origem(4'b0001, 2'b01);
      destinoBot = 4'b0010;
      pedido_aceito = 1'b1;
      @(negedge clock);
      check("erro_cheia_pop", erroPedido, 1);
      tick();
      destinoBot = '0;
      pedido_aceito = 1'b0;
      check("ocupacao_cheia_pop", ocupacao, 3);

      // Drain, then a pop on an empty FIFO is ignored
      pop(); pop(); pop();
      check("valido_vazia", pedido_valido, 0);
      check("ocupacao_vazia", ocupacao, 0);
      pop();
      check("pop_vazia", ocupacao, 0);

      // Simultaneous push and pop keeps the count
      origem(4'b0100, 2'b11); sb.push_back({2'd2, 2'd0, 2'd3}); destino(4'b0001, 1'b0);
      origem(4'b1000, 2'b00);
      sb.push_back({2'd3, 2'd1, 2'd0});
      destinoBot = 4'b0010;
      pedido_aceito = 1'b1;
      @(negedge clock);
      check("erro_push_pop", erroPedido, 0);
      tick();
      destinoBot = '0;
      pedido_aceito = 1'b0;
      check("ocupacao_push_pop", ocupacao, 1);
      check("cabeca_push_pop", {pedido_origem, pedido_destino, pedido_tipo}, {2'd3, 2'd1, 2'd0});
      pop();
      check("ocupacao_push_pop_fim", ocupacao, 0);

      // Destination timeout
      origem(4'b0100, 2'b00);
`ifdef SMART_CARGO_TIMEOUT_EN
      for (int k = 2; k <= 8; k++) begin
         @(negedge clock);
         check("timeout_erro", erroPedido, (k == 8));
         tick();
      end
      check("timeout_esperando", esperandoDestino, 0);
`else
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         check("sem_timeout_esperando", esperandoDestino, 1);
         tick();
      end
      destino(4'b0100, 1'b1);
`endif

      // Asynchronous reset with two queued entries and a pending origin
      origem(4'b0001, 2'b01); sb.push_back({2'd0, 2'd1, 2'd1}); destino(4'b0010, 1'b0);
      origem(4'b0010, 2'b10); sb.push_back({2'd1, 2'd3, 2'd2}); destino(4'b1000, 1'b0);
      origem(4'b1000, 2'b11);
      check("pre_reset_ocupacao", ocupacao, 2);
      check("pre_reset_esperando", esperandoDestino, 1);
      origemBot = 4'b0001;
      #2;
      reset = 1'b1;
      #1;
      check("async_valido", pedido_valido, 0);
      check("async_ocupacao", ocupacao, 0);
      check("async_esperando", esperandoDestino, 0);
      check("async_erro", erroPedido, 0);
      check("async_head", {pedido_origem, pedido_destino, pedido_tipo}, 0);
      sb.delete();
      repeat (2) tick();
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("botao_preso", esperandoDestino, 0);
         tick();
      end
      origemBot = '0;
      tick();
      origem(4'b0001, 2'b00);
      check("pos_reset_origem", esperandoDestino, 1);
      sb.push_back({2'd0, 2'd2, 2'd0});
      destino(4'b0100, 1'b0);
      check("pos_reset_ocupacao", ocupacao, 1);
      pop();
      check("pos_reset_fim", ocupacao, 0);
      check("scoreboard_vazio", sb.size(), 0);

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
